// File: rtl/alu.sv
// Two-operand integer ALU for the single-cycle MIPS datapath.
// Eight operations are selected by a 3-bit opcode. Result, zero flag and
// signed-overflow flag are registered together on the rising clock edge,
// one cycle after the operands are presented.
module alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] operandA,
    input  logic [DATA_WIDTH-1:0] operandB,
    input  logic [2:0]            aluOp,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zeroFlag,
    output logic                  overflowFlag
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    localparam int MSB = DATA_WIDTH - 1;

    // Same-sign operands whose sum changes sign have wrapped.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                          input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Opposite-sign operands whose difference disagrees with A's sign have wrapped.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    // Widen a single compare bit to a full zero-extended word.
    function automatic logic [DATA_WIDTH-1:0] zext_bit(input logic b);
        return {{(DATA_WIDTH-1){1'b0}}, b};
    endfunction

    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic        [DATA_WIDTH-1:0] sum_p0;
    logic        [DATA_WIDTH-1:0] diff_p0;
    logic                         lt_signed_p0;
    logic                         lt_unsigned_p0;
    logic        [DATA_WIDTH-1:0] next_result_p0;
    logic                         next_overflow_p0;
    logic                         next_zero_p0;

    assign a_s = $signed(operandA);
    assign b_s = $signed(operandB);

    // Shared arithmetic; the signed compare is a true magnitude compare so it
    // stays correct when A - B would overflow.
    always_comb begin
        sum_p0         = operandA + operandB;
        diff_p0        = operandA - operandB;
        lt_signed_p0   = (a_s < b_s);
        lt_unsigned_p0 = (operandA < operandB);
    end

    // Operation select and flag generation feeding the output registers.
    always_comb begin
        next_result_p0   = '0;
        next_overflow_p0 = 1'b0;
        case (aluOp)
            OP_ADD: begin
                next_result_p0   = sum_p0;
                next_overflow_p0 = add_overflow(operandA[MSB], operandB[MSB], sum_p0[MSB]);
            end
            OP_SUB: begin
                next_result_p0   = diff_p0;
                next_overflow_p0 = sub_overflow(operandA[MSB], operandB[MSB], diff_p0[MSB]);
            end
            OP_AND:  next_result_p0 = operandA & operandB;
            OP_OR:   next_result_p0 = operandA | operandB;
            OP_XOR:  next_result_p0 = operandA ^ operandB;
            OP_NOR:  next_result_p0 = ~(operandA | operandB);
            OP_SLT:  next_result_p0 = zext_bit(lt_signed_p0);
            OP_SLTU: next_result_p0 = zext_bit(lt_unsigned_p0);
            default: next_result_p0 = '0;
        endcase
        next_zero_p0 = (next_result_p0 == '0);
    end

    // ---- stage boundary: p0 -> registered outputs ----
    // Capture result and flags together so zeroFlag always describes result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result       <= '0;
            zeroFlag     <= 1'b1;
            overflowFlag <= 1'b0;
        end else begin
            result       <= next_result_p0;
            zeroFlag     <= next_zero_p0;
            overflowFlag <= next_overflow_p0;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
module tb_alu;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic [2:0]   aluOp;
    logic [W-1:0] result;
    logic         zeroFlag;
    logic         overflowFlag;

    int vectors;
    int miscompares;

    alu #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .operandA     (operandA),
        .operandB     (operandB),
        .aluOp        (aluOp),
        .result       (result),
        .zeroFlag     (zeroFlag),
        .overflowFlag (overflowFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic [W-1:0] exp_r,
                             input logic exp_z, input logic exp_v);
        vectors++;
        assert (result === exp_r) else begin
            miscompares++;
            $error("FAIL %s result: observed %h expected %h", tag, result, exp_r);
        end
        vectors++;
        assert (zeroFlag === exp_z) else begin
            miscompares++;
            $error("FAIL %s zeroFlag: observed %b expected %b", tag, zeroFlag, exp_z);
        end
        vectors++;
        assert (overflowFlag === exp_v) else begin
            miscompares++;
            $error("FAIL %s overflowFlag: observed %b expected %b", tag, overflowFlag, exp_v);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic [W-1:0] exp_r,
                          input logic exp_z, input logic exp_v);
        @(negedge clk);
        operandA = a;
        operandB = b;
        aluOp    = op;
        @(posedge clk);
        #1;
        check_out(tag, exp_r, exp_z, exp_v);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        operandA    = '0;
        operandB    = '0;
        aluOp       = 3'b000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_init", 32'h0000_0000, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Arithmetic
        run_op("add",      32'hAABB_CCDD, 32'h0011_2233, 3'b000, 32'hAACC_EF10, 1'b0, 1'b0);
        run_op("sub",      32'hAABB_CCDD, 32'h0011_2233, 3'b001, 32'hAAAA_AAAA, 1'b0, 1'b0);
        run_op("sub_zero", 32'h1234_5678, 32'h1234_5678, 3'b001, 32'h0000_0000, 1'b1, 1'b0);

        // Overflow boundaries
        run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 32'h8000_0000, 1'b0, 1'b1);
        run_op("and_novf", 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 3'b001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("and_novf2",32'h8000_0000, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_neg_ovf", 32'h8000_0000, 32'h8000_0000, 3'b000, 32'h0000_0000, 1'b1, 1'b1);

        // Logic ops
        run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'hF000_F000, 1'b0, 1'b0);
        run_op("or",  32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'hFFF0_FFF0, 1'b0, 1'b0);
        run_op("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h0FF0_0FF0, 1'b0, 1'b0);
        run_op("nor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101, 32'h000F_000F, 1'b0, 1'b0);

        // Compares
        run_op("slt_neg",  32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sltu_big", 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0000, 1'b1, 1'b0);
        run_op("slt_wrap", 32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sltu_small", 32'h0000_0001, 32'hFFFF_FFFF, 3'b111, 32'h0000_0001, 1'b0, 1'b0);
        run_op("slt_false", 32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 32'h0000_0000, 1'b1, 1'b0);

        // Held inputs give held outputs
        @(posedge clk);
        #1;
        check_out("hold", 32'h0000_0000, 1'b1, 1'b0);

        // Asynchronous reset between edges after a nonzero result
        run_op("pre_reset", 32'hAABB_CCDD, 32'h0011_2233, 3'b001, 32'hAAAA_AAAA, 1'b0, 1'b0);
        @(negedge clk);
        operandA = 32'h0000_0001;
        operandB = 32'h0000_0002;
        aluOp    = 3'b000;
        #1;
        reset = 1'b1;
        #1;
        check_out("async_reset", 32'h0000_0000, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_out("post_reset_add", 32'h0000_0003, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
